// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a byte-wide data RAM.
// Splits word/half/byte accesses into little-endian byte beats and extends loaded data.
module load_store_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_mode,
  input  logic                  i_req_unsigned,
  input  logic [WIDTH-1:0]      i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_resp_valid,
  output logic [WIDTH-1:0]      o_resp_rdata,
  output logic                  o_resp_misaligned,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_we;
  logic [1:0]            r_mode;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [1:0]            r_beats_m1;
  logic [1:0]            r_count;
  logic [WIDTH-1:0]      r_rdata_buf;
  logic [WIDTH-1:0]      w_load_word;
  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_last_beat;
  logic                  w_unused_addr_hi;

  // Byte/half extension from bit 7/15; the sign bit is masked for unsigned loads.
  function automatic logic [WIDTH-1:0] extend_load(input logic [WIDTH-1:0] word,
                                                   input logic [1:0]       mode,
                                                   input logic             uns);
    case (mode)
      2'b00:   extend_load = {{(WIDTH-8){word[7] & ~uns}}, word[7:0]};
      2'b01:   extend_load = {{(WIDTH-16){word[15] & ~uns}}, word[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  assign w_unused_addr_hi = &{1'b0, i_req_addr[WIDTH-1:ADDR_WIDTH]};
  assign w_accept         = (r_state == IDLE) && i_req_valid;
  assign w_last_beat      = (r_count == r_beats_m1);
  assign w_misaligned     = (i_req_mode == 2'b11) ||
                            ((i_req_mode == 2'b01) && i_req_addr[0]) ||
                            ((i_req_mode == 2'b10) && (i_req_addr[1:0] != 2'b00));

  // Current beat's RAM byte merged into the lane buffer, so the final beat needs no extra cycle.
  always_comb begin
    w_load_word = r_rdata_buf;
    w_load_word[{r_count, 3'b000} +: 8] = i_mem_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_req_valid) w_next_state = w_misaligned ? RESP : ACCESS;
      ACCESS:  if (w_last_beat) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Aligned bases have zero low bits wherever the beat count is non-zero, so OR is a carry-free add.
  always_comb begin
    o_req_ready  = (r_state == IDLE);
    o_resp_valid = (r_state == RESP);
    o_mem_we     = (r_state == ACCESS) && r_we;
    o_mem_addr   = {r_addr[ADDR_WIDTH-1:2], r_addr[1:0] | r_count};
    o_mem_wdata  = r_wdata[{r_count, 3'b000} +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count           <= 2'd0;
      o_resp_rdata      <= '0;
      o_resp_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= 2'd0;
          if (i_req_valid && w_misaligned) begin
            o_resp_rdata      <= '0;
            o_resp_misaligned <= 1'b1;
          end
        end
        ACCESS: begin
          r_count <= r_count + 2'd1;
          if (w_last_beat) begin
            o_resp_rdata      <= r_we ? '0 : extend_load(w_load_word, r_mode, r_unsigned);
            o_resp_misaligned <= 1'b0;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we       <= i_req_we;
      r_mode     <= i_req_mode;
      r_unsigned <= i_req_unsigned;
      r_addr     <= i_req_addr[ADDR_WIDTH-1:0];
      r_wdata    <= i_req_wdata;
      r_beats_m1 <= (i_req_mode == 2'b00) ? 2'd0 : (i_req_mode == 2'b01) ? 2'd1 : 2'd3;
    end
    if ((r_state == ACCESS) && !r_we)
      r_rdata_buf[{r_count, 3'b000} +: 8] <= i_mem_rdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wide RAM model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_mode;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:131071];
  logic        tb_wr;
  logic [16:0] tb_wr_addr;
  logic [7:0]  tb_wr_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_resp  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t tbl [14];

  load_store_unit #(.WIDTH(32), .ADDR_WIDTH(17)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_mode(req_mode), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_misaligned(resp_misaligned),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     ram[mem_addr]   <= mem_wdata;
    else if (tb_wr) ram[tb_wr_addr] <= tb_wr_data;
  end

  always @(negedge clk) if (resp_valid) n_resp <= n_resp + 1;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_wr_addr = a; tb_wr_data = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic set_req(input vec_t v);
    req_we = v.we; req_mode = v.mode; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  lat;
    int  we_cnt;
    bit  done;
    @(negedge clk);
    chk("ready_before", idx, 32'(req_ready), 32'd1);
    set_req(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    done = 1'b0; lat = 0; we_cnt = 0;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        done = 1'b1;
        lat  = k;
      end else begin
        if (mem_we) we_cnt++;
        chk("mem_addr", idx, 32'(mem_addr), 32'(17'(v.addr[16:0] + 17'(k - 1))));
      end
    end
    if (!done) chk("resp_timeout", idx, 32'd0, 32'd1);
    chk("latency", idx, lat, v.exp_lat);
    chk("rdata", idx, resp_rdata, v.exp_rdata);
    chk("misaligned", idx, 32'(resp_misaligned), 32'(v.exp_mis));
    chk("we_in_resp", idx, 32'(mem_we), 32'd0);
    chk("we_cycles", idx, we_cnt, v.exp_we);
    @(negedge clk);
    chk("resp_one_cycle", idx, 32'(resp_valid), 32'd0);
    chk("ready_after", idx, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int base;
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; tb_wr = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;

    //               we    mode   uns   addr      wdata         exp_rdata     mis  lat we
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h44332211, 1'b0, 5, 0};
    tbl[1]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h00004433, 1'b0, 3, 0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h120, 32'h0,        32'hFFFFF234, 1'b0, 3, 0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h120, 32'h0,        32'h0000F234, 1'b0, 3, 0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h00000022, 1'b0, 2, 0};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0};
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 32'h201, 32'hDEADBEEF, 32'h0,        1'b1, 1, 0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        32'h00000011, 1'b0, 2, 0};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0,        1'b0, 3, 2};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h204, 32'h01020304, 32'h0,        1'b0, 5, 4};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h204, 32'h0,        32'h01020304, 1'b0, 5, 0};
    tbl[12] = '{1'b1, 2'b00, 1'b0, 32'h208, 32'h000000AB, 32'h0,        1'b0, 2, 1};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 32'h208, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};

    @(posedge clk); #1;
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    poke(17'h120, 8'h34); poke(17'h121, 8'hF2); poke(17'h202, 8'h5A);
    poke(17'h300, 8'h99); poke(17'h301, 8'h99); poke(17'h302, 8'h99); poke(17'h303, 8'h99);

    @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
    chk("rst_rdata", 0, resp_rdata, 32'd0);
    chk("rst_misaligned", 0, 32'(resp_misaligned), 32'd0);
    chk("rst_mem_we", 0, 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i], i);
      if (i == 9) begin
        chk("sh_ram200", i, 32'(ram[17'h200]), 32'hEF);
        chk("sh_ram201", i, 32'(ram[17'h201]), 32'hBE);
        chk("sh_ram202", i, 32'(ram[17'h202]), 32'h5A);
      end
    end

    // Sign/zero extension of a byte with bit 7 set
    @(negedge clk);
    poke(17'h103, 8'h80);
    v = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0};
    run_vec(v, 20);
    v = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 2, 0};
    run_vec(v, 21);
    @(negedge clk);
    poke(17'h103, 8'h44);

    // Reset in the same cycle as a request: nothing accepted
    @(negedge clk);
    v = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0};
    set_req(v);
    req_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rstreq_ready", 30, 32'(req_ready), 32'd1);
    chk("rstreq_mem_we", 30, 32'(mem_we), 32'd0);
    chk("rstreq_resp", 30, 32'(resp_valid), 32'd0);

    // Reset after two store beats have been written
    @(negedge clk);
    base = n_resp;
    v = '{1'b1, 2'b10, 1'b0, 32'h300, 32'hA1B2C3D4, 32'h0, 1'b0, 0, 0};
    set_req(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_we_beat1", 31, 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", 31, 32'(req_ready), 32'd1);
    chk("rstmid_mem_we", 31, 32'(mem_we), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_resp", 31, 32'(resp_valid), 32'd0);
    end
    chk("rstmid_resp_count", 31, n_resp - base, 32'd0);
    chk("rstmid_ram300", 31, 32'(ram[17'h300]), 32'hD4);
    chk("rstmid_ram301", 31, 32'(ram[17'h301]), 32'hC3);
    chk("rstmid_ram302", 31, 32'(ram[17'h302]), 32'h99);
    chk("rstmid_ram303", 31, 32'(ram[17'h303]), 32'h99);

    // Back-to-back with req_valid held high
    @(negedge clk);
    base = n_resp;
    v = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0};
    set_req(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0, 1'b0, 0, 0};
    set_req(v);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("b2b_busy_ready", 40 + k, 32'(req_ready), 32'd0);
      chk("b2b_busy_resp", 40 + k, 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    chk("b2b_resp1", 45, 32'(resp_valid), 32'd1);
    chk("b2b_rdata1", 45, resp_rdata, 32'h44332211);
    chk("b2b_resp1_ready", 45, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_gap_resp", 46, 32'(resp_valid), 32'd0);
    chk("b2b_gap_ready", 46, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepted2", 47, 32'(req_ready), 32'd0);
    chk("b2b_access2_resp", 47, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_resp2", 48, 32'(resp_valid), 32'd1);
    chk("b2b_rdata2", 48, resp_rdata, 32'h00000044);
    @(negedge clk);
    chk("b2b_end_resp", 49, 32'(resp_valid), 32'd0);
    chk("b2b_end_ready", 49, 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_resp_count", 49, n_resp - base, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences every load and store between the core's execute stage and the byte-organised data RAM (`ram_array`, 8-bit entries). One word, halfword or byte access is split into 1–4 little-endian byte beats. Loaded data is returned sign- or zero-extended, ready for the writeback result mux. Misaligned and reserved-mode requests are rejected without touching memory. `req_ready` low acts as the core's stall.

## Interface
- `WIDTH`, 32, data/address width of the core side
- `ADDR_WIDTH`, 17, byte-address width of the data RAM (2**17 bytes)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle and can accept; request accepted on an edge with `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_mode`  in  2  access size (`address_mode`): 00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  WIDTH  byte address (ALU result)
- `req_wdata`  in  WIDTH  store data, low bytes used per mode
- `resp_valid`  out  1  one-cycle pulse, request complete
- `resp_rdata`  out  WIDTH  extended load data (0 for stores and errors); held until next response
- `resp_misaligned`  out  1  qualifies `resp_valid`: request rejected
- `mem_addr`  out  ADDR_WIDTH  byte address to RAM
- `mem_we`  out  1  RAM byte write enable
- `mem_wdata`  out  8  RAM write byte
- `mem_rdata`  in  8  RAM read byte, combinational from `mem_addr` in the same cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept: latch we/mode/unsigned/addr[ADDR_WIDTH-1:0]/wdata.
  - Set beats = 1/2/4 for mode 00/01/10, and beat counter=0.
  - Misaligned if mode=01 with addr[0]=1, mode=10 with addr[1:0]≠0, or mode=11.
  - Misaligned → RESP with error flag set, no ACCESS cycles. Otherwise → ACCESS.
- **ACCESS**, one cycle per beat
  - `mem_addr` = base + count; alignment guarantees no carry past bit 1.
  - Store: `mem_we`=1, `mem_wdata` = wdata byte[count].
  - Load: `mem_we`=0; capture `mem_rdata` into byte lane[count] at the edge.
  - count increments each cycle. When count = beats−1 → RESP.
- **RESP**
  - `resp_valid`=1. `resp_rdata` and `resp_misaligned` are registered on entry.
  - Load data: byte/half extended from bit 7/15 per `req_unsigned`; word passed through.
  - Store or error: rdata = 0.
  - Next state IDLE.
- `mem_we`=0 in IDLE and RESP; `mem_addr`/`mem_wdata` don't-care there.
- `req_ready`=0 in ACCESS and RESP; `req_valid` is ignored there.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_misaligned`=0, `mem_we`=0, count=0.
- Latency, with acceptance on edge E0:
  - ACCESS occupies cycles E0+1 … E0+beats.
  - `resp_valid` is high in cycle E0+beats+1.
  - Byte: 2 cycles to response. Half: 3. Word: 5. Misaligned: 1.
- RAM write for beat k lands on the edge ending ACCESS cycle k.
- Back-to-back: `req_ready` returns 1 in the cycle after RESP. Throughput is one request per beats+2 cycles (misaligned: one per 2).
- Reset mid-ACCESS: returns to IDLE on that edge, no response issued. `mem_we`=0 from the next cycle. Store bytes already written stay written (no rollback).
- Reset asserted in the same cycle as `req_valid`: reset wins, request not accepted.

## Test plan
- **Word load:** RAM[0x100..0x103]=0x11,0x22,0x33,0x44; LW addr 0x100 → `resp_valid` 5 cycles after accept, `resp_rdata`=0x44332211, `resp_misaligned`=0; `mem_addr` sequence 0x100,0x101,0x102,0x103.
- **Byte load extension:** RAM[0x103]=0x80.
  - LB (`req_unsigned`=0) at 0x103 → 0xFFFFFF80.
  - LBU at 0x103 → 0x00000080.
  - Each responds 2 cycles after accept.
- **Halfword store:** SH addr 0x200 wdata 0xDEADBEEF → RAM[0x200]=0xEF, RAM[0x201]=0xBE, RAM[0x202] unchanged; `resp_rdata`=0; exactly 2 cycles with `mem_we`=1.
- **Misaligned / reserved:**
  - LW at 0x102, SH at 0x201 and mode 11 at 0x0 → `resp_misaligned`=1 and `resp_rdata`=0, one cycle after accept.
  - `mem_we` never asserted.
  - Following aligned request served normally.
- **Reset mid-store:** SW 0x300 wdata 0xA1B2C3D4, assert `rst` after 2 beats → next cycle IDLE, `req_ready`=1, `resp_valid` never pulses; RAM[0x300]=0xD4, RAM[0x301]=0xC3, RAM[0x302..0x303] unchanged.
- **Back-to-back:** `req_valid` held high with LW 0x100 then LB 0x103 → second accepted in the cycle after the first `resp_valid`; responses 0x44332211 then 0x00000044 (LBU) with no lost or duplicated pulse.
